coin_accumulator: RTL

- Upstream front-end for venmachine. Turns raw coin-sensor levels and customer buttons into the `fives`/`tens` coin counts that venmachine consumes.
- Collects coins over one transaction. On a vend request it presents the accumulated counts for a fixed hold window, then clears them.
- On cancel or inactivity timeout it refunds the collected coins instead of presenting them.

---
 rtl/vend_pkg.sv | 24 ++
 rtl/edge_detect.sv | 20 ++
 rtl/coin_accumulator.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending front-end.
// Used by coin_accumulator and the downstream venmachine.
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      PRESENT,
      REFUND
   } state_t;

   localparam int COIN5_VAL  = 5;
   localparam int COIN10_VAL = 10;
   localparam int DEF_CNT_W  = 3;

   // 5*c5 + 10*c10 built from shifts; operands are pre-zero-extended.
   function automatic logic [6:0] credit_of(
      input logic [6:0] c5,
      input logic [6:0] c10
   );
      return (c5 << 2) + c5 + (c10 << 3) + (c10 << 1);
   endfunction

endpackage

// File: rtl/edge_detect.sv
// Single-bit rising-edge detector.
// The previous level is zero after reset, so a level already high counts once.
module edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic din_q;

   // Remember last cycle's level.
   always_ff @(posedge clk) begin
      if (reset) din_q <= 1'b0;
      else       din_q <= din;
   end

   assign rise = din & ~din_q;

endmodule

// File: rtl/coin_accumulator.sv
// Coin collection front-end: counts coins, presents them on vend,
// refunds them on cancel or inactivity timeout.
module coin_accumulator
   import vend_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int MAX_COINS   = 7,
   parameter int TIMEOUT_CYC = 64,
   parameter int HOLD_CYC    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             coin_five_in,
   input  logic             coin_ten_in,
   input  logic             vend_req,
   input  logic             cancel_req,
   output logic [CNT_W-1:0] fives,
   output logic [CNT_W-1:0] tens,
   output logic             present,
   output logic             busy,
   output logic [6:0]       credit,
   output logic             coin_reject,
   output logic             refund,
   output logic [CNT_W-1:0] refund_fives,
   output logic [CNT_W-1:0] refund_tens
);

   localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
   localparam int HLD_W = $clog2(HOLD_CYC) + 1;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COINS);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_CYC - 1);

   state_t           state;
   state_t           nxt;
   logic [CNT_W-1:0] cnt5;
   logic [CNT_W-1:0] cnt10;
   logic [TMR_W-1:0] tmr;
   logic [HLD_W-1:0] hold;
   logic             reject_q;

   logic e5;
   logic e10;
   logic ev;
   logic ec;
   logic any_coin;
   logic timeout;
   logic hold_done;
   logic accepting;
   logic rej_now;

   edge_detect u_ed5 (
      .clk   (clk),
      .reset (reset),
      .din   (coin_five_in),
      .rise  (e5)
   );

   edge_detect u_ed10 (
      .clk   (clk),
      .reset (reset),
      .din   (coin_ten_in),
      .rise  (e10)
   );

   edge_detect u_edv (
      .clk   (clk),
      .reset (reset),
      .din   (vend_req),
      .rise  (ev)
   );

   edge_detect u_edc (
      .clk   (clk),
      .reset (reset),
      .din   (cancel_req),
      .rise  (ec)
   );

   assign any_coin  = e5 | e10;
   // A coin in the final idle cycle restarts the timer instead of refunding.
   assign timeout   = (tmr == TMR_LAST) && !any_coin;
   assign hold_done = (hold == HLD_LAST);
   assign accepting = (state == IDLE) || (state == COLLECT);

   // Coins are refused when saturated, or outright outside collection.
   always_comb begin
      rej_now = 1'b0;
      if (accepting) begin
         rej_now = (e5  && (cnt5  >= CNT_MAX)) ||
                   (e10 && (cnt10 >= CNT_MAX));
      end else begin
         rej_now = any_coin;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nxt;
   end

   // Next-state selection; cancel beats vend, both beat timeout.
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE: begin
            if (any_coin) nxt = COLLECT;
         end
         COLLECT: begin
            if (ec)           nxt = REFUND;
            else if (ev)      nxt = PRESENT;
            else if (timeout) nxt = REFUND;
         end
         PRESENT: begin
            if (hold_done) nxt = IDLE;
         end
         REFUND: begin
            nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // State-decoded outputs; counts only leave the block when valid.
   always_comb begin
      busy         = (state != IDLE);
      present      = 1'b0;
      fives        = '0;
      tens         = '0;
      refund       = 1'b0;
      refund_fives = '0;
      refund_tens  = '0;
      unique case (state)
         PRESENT: begin
            present = 1'b1;
            fives   = cnt5;
            tens    = cnt10;
         end
         REFUND: begin
            refund       = 1'b1;
            refund_fives = cnt5;
            refund_tens  = cnt10;
         end
         default: ;
      endcase
   end

   // Coin counters, idle timer, hold timer and the reject pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt5     <= '0;
         cnt10    <= '0;
         tmr      <= '0;
         hold     <= '0;
         reject_q <= 1'b0;
      end else begin
         reject_q <= rej_now;
         if (state == COLLECT && !any_coin) tmr <= tmr + TMR_W'(1);
         else                               tmr <= '0;
         if (state == PRESENT) hold <= hold + HLD_W'(1);
         else                  hold <= '0;
         if (accepting) begin
            if (e5 && (cnt5 < CNT_MAX))   cnt5  <= cnt5 + CNT_W'(1);
            if (e10 && (cnt10 < CNT_MAX)) cnt10 <= cnt10 + CNT_W'(1);
         end else if (state == REFUND || hold_done) begin
            cnt5  <= '0;
            cnt10 <= '0;
         end
      end
   end

   assign coin_reject = reject_q;
   assign credit      = credit_of(7'(cnt5), 7'(cnt10));

endmodule
